reduce_nway: RTL and testbench

Parametrised, pipelined N-input bit-reduction unit, the successor to the fixed 8-input AND gate in the components library. It reduces an N-bit input vector to one bit with a per-beat selectable operator (AND, OR, XOR, XNOR) through a balanced binary tree that has one register stage per tree level. It carries a valid/ready handshake on both sides so that datapath blocks can stream vectors through it at one beat per cycle under backpressure.

---
 rtl/reduce_nway.sv | 113 +++++++++++
 tb/tb_reduce_nway.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_nway.sv
// reduce_nway: pipelined N-input bit reduction (AND / OR / XOR / XNOR).
// A balanced binary tree with one register stage per level. The operator
// travels with its beat. A single global enable stalls the whole pipe
// under output backpressure.
//
// Handshake: a beat is taken on a rising edge where in_valid && in_ready,
// and a result is handed over on a rising edge where out_valid && out_ready.
// in_ready is low only while a valid result is held against out_ready=0.
// Bubbles are not squeezed out: every stage advances whenever the pipe is
// enabled.
module reduce_nway #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_vec,
    input  logic [1:0]   in_op,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_bit,
    output logic         out_valid,
    input  logic         out_ready
);
    // Tree depth (= latency in cycles) and padded leaf count.
    localparam int D  = $clog2(N);
    localparam int W  = 1 << D;
    // Operator registers for stages 1..D-1. The last stage's operator has
    // already been applied when its result is registered, so it is not kept.
    localparam int OW = (D > 1) ? 2 * (D - 1) : 2;
    // Width of levels 0..D-1 laid side by side (W + W/2 + ... + 2).
    localparam int FW = 2 * W - 2;

    logic          pad;
    logic [W-1:0]  leaves;
    logic [D-1:0]  v_q;      // bit s-1 = valid of stage s
    logic [OW-1:0] op_q;     // bits [2(s-1)+:2] = operator of stage s
    logic [OW+1:0] op_all;   // index 0 = incoming operator, then stages
    // Node bits of levels 1..D. Level L starts at W - 2^(D-L+1), so the
    // root (level D) is the top bit.
    logic [W-2:0]  node_q;
    logic [W-2:0]  node_d;
    // Levels 0..D-1 as seen by the next level. Level L starts at
    // 2W - 2^(D-L+1).
    logic [FW-1:0] full;
    logic          en;
    logic          a;
    logic          b;
    logic          r;
    logic [1:0]    o;

    assign pad    = (in_op == 2'b00);
    assign op_all = {op_q, in_op};

    // Leaves: input bits, padded above N with the operator's identity.
    always_comb begin
        leaves         = {W{pad}};
        leaves[N-1:0]  = in_vec;
    end

    // Gather the sources of every tree level: leaves, then stage nodes.
    always_comb begin
        full         = '0;
        full[W-1:0]  = leaves;
        for (int i = 0; i < W - 2; i++) begin
            full[W + i] = node_q[i];
        end
    end

    // Pairwise combine of each level into the next; XNOR inverts at the root.
    always_comb begin
        node_d = '0;
        a      = 1'b0;
        b      = 1'b0;
        r      = 1'b0;
        o      = 2'b00;
        for (int l = 1; l <= D; l++) begin
            for (int k = 0; k < (W >> l); k++) begin
                a = full[(2 * W - (1 << (D - l + 2))) + 2 * k];
                b = full[(2 * W - (1 << (D - l + 2))) + 2 * k + 1];
                o = op_all[2 * (l - 1) +: 2];
                case (o)
                    2'b00:   r = a & b;
                    2'b01:   r = a | b;
                    default: r = a ^ b;
                endcase
                if (l == D && o == 2'b11) begin
                    r = ~r;
                end
                node_d[(W - (1 << (D - l + 1))) + k] = r;
            end
        end
    end

    // Pipeline registers: the whole pipe shifts one stage whenever enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            op_q   <= '0;
            node_q <= '0;
        end else if (en) begin
            v_q    <= (v_q << 1) | D'(in_valid);
            op_q   <= op_all[OW-1:0];
            node_q <= node_d;
        end
    end

    assign out_valid = v_q[D-1];
    assign out_bit   = node_q[W-2];
    // Stall only when a finished result is being refused downstream.
    assign en        = !(out_valid && !out_ready);
    assign in_ready  = en;

endmodule

// File: tb/tb_reduce_nway.sv
// Directed bench for reduce_nway: an N=8 and an N=5 instance. Inputs
// change 1ns after a rising edge; outputs are sampled on the falling edge.
module tb_reduce_nway;
    logic       clk = 1'b0;
    logic       rst_n;

    logic [7:0] vec8;
    logic [1:0] op8;
    logic       valid8;
    logic       ready8;
    logic       obit8;
    logic       ovalid8;
    logic       oready8;

    logic [4:0] vec5;
    logic [1:0] op5;
    logic       valid5;
    logic       ready5;
    logic       obit5;
    logic       ovalid5;
    logic       oready5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reduce_nway #(.N(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (vec8),
        .in_op     (op8),
        .in_valid  (valid8),
        .in_ready  (ready8),
        .out_bit   (obit8),
        .out_valid (ovalid8),
        .out_ready (oready8)
    );

    reduce_nway #(.N(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vec    (vec5),
        .in_op     (op5),
        .in_valid  (valid5),
        .in_ready  (ready5),
        .out_bit   (obit5),
        .out_valid (ovalid5),
        .out_ready (oready5)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid8  = 1'b0;
        valid5  = 1'b0;
        oready8 = 1'b1;
        oready5 = 1'b1;
        repeat (n) next_cycle();
    endtask

    // Reset holds everything empty even with in_valid high; first beat after release.
    task automatic test_reset();
        logic exp_v;
        rst_n   = 1'b0;
        vec8    = 8'hFF;
        op8     = 2'b00;
        valid8  = 1'b1;
        oready8 = 1'b1;
        vec5    = 5'h1F;
        op5     = 2'b00;
        valid5  = 1'b1;
        oready5 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ovalid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", ovalid8); end
        checks++;
        if (obit8 !== 1'b0) begin errors++; $display("FAIL reset_out_bit got %b expected 0", obit8); end
        checks++;
        if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", ready8); end
        checks++;
        if (ovalid5 !== 1'b0) begin errors++; $display("FAIL reset_out_valid_n5 got %b expected 0", ovalid5); end
        next_cycle();
        rst_n  = 1'b1;
        valid5 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) valid8 = 1'b0;
            @(negedge clk);
            exp_v = (c == 3);
            checks++;
            if (ovalid8 !== exp_v) begin
                errors++; $display("FAIL first_beat_valid c=%0d got %b expected %b", c, ovalid8, exp_v);
            end
            if (c == 3) begin
                checks++;
                if (obit8 !== 1'b1) begin errors++; $display("FAIL first_beat_bit got %b expected 1", obit8); end
            end
            next_cycle();
        end
    endtask

    // Four operators back to back, N=8.
    task automatic test_op_sweep();
        logic [7:0] sv [4];
        logic [1:0] so [4];
        logic       se [4];
        logic       exp_v;
        sv = '{8'hFE, 8'h00, 8'h07, 8'h07};
        so = '{2'b00, 2'b01, 2'b10, 2'b11};
        se = '{1'b0, 1'b0, 1'b1, 1'b0};
        oready8 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                vec8 = sv[c]; op8 = so[c]; valid8 = 1'b1;
            end else begin
                valid8 = 1'b0;
            end
            @(negedge clk);
            exp_v = (c >= 3 && c <= 6);
            checks++;
            if (ovalid8 !== exp_v) begin
                errors++; $display("FAIL sweep_valid c=%0d got %b expected %b", c, ovalid8, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (obit8 !== se[c-3]) begin
                    errors++; $display("FAIL sweep_bit beat=%0d got %b expected %b", c - 3, obit8, se[c-3]);
                end
            end
            next_cycle();
        end
    endtask

    // Non-power-of-two width: padding must use the operator's identity.
    task automatic test_non_pow2();
        logic [4:0] sv [5];
        logic [1:0] so [5];
        logic       se [5];
        logic       exp_v;
        sv = '{5'h1F, 5'h00, 5'h13, 5'h13, 5'h10};
        so = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        se = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        oready5 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c < 5) begin
                vec5 = sv[c]; op5 = so[c]; valid5 = 1'b1;
            end else begin
                valid5 = 1'b0;
            end
            @(negedge clk);
            exp_v = (c >= 3 && c <= 7);
            checks++;
            if (ovalid5 !== exp_v) begin
                errors++; $display("FAIL n5_valid c=%0d got %b expected %b", c, ovalid5, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (obit5 !== se[c-3]) begin
                    errors++; $display("FAIL n5_bit beat=%0d got %b expected %b", c - 3, obit5, se[c-3]);
                end
            end
            next_cycle();
        end
    endtask

    // Six beats with a four-cycle stall starting when the first result shows.
    task automatic test_backpressure();
        logic [7:0] bv [6];
        logic [1:0] bo [6];
        logic       be [6];
        logic       stall;
        int         idx;
        int         got;
        bv = '{8'h01, 8'h03, 8'hFF, 8'h80, 8'h00, 8'h0F};
        bo = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        be = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        idx = 0;
        got = 0;
        for (int c = 0; c < 20; c++) begin
            stall   = (c >= 3 && c <= 6);
            oready8 = !stall;
            if (idx < 6) begin
                vec8 = bv[idx]; op8 = bo[idx]; valid8 = 1'b1;
            end else begin
                valid8 = 1'b0;
            end
            @(negedge clk);
            if (stall) begin
                checks++;
                if (ready8 !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got %b expected 0", c, ready8); end
                checks++;
                if (ovalid8 !== 1'b1) begin errors++; $display("FAIL stall_out_valid c=%0d got %b expected 1", c, ovalid8); end
                checks++;
                if (obit8 !== be[0]) begin errors++; $display("FAIL stall_out_bit c=%0d got %b expected %b", c, obit8, be[0]); end
            end
            if (ovalid8 === 1'b1 && oready8 === 1'b1) begin
                checks++;
                if (got >= 6) begin
                    errors++; $display("FAIL bp_extra_output c=%0d got %b expected none", c, obit8);
                end else if (obit8 !== be[got]) begin
                    errors++; $display("FAIL bp_order beat=%0d got %b expected %b", got, obit8, be[got]);
                end
                got++;
            end
            if (valid8 === 1'b1 && ready8 === 1'b1) idx++;
            next_cycle();
        end
        checks++;
        if (got != 6) begin errors++; $display("FAIL bp_delivered got %0d expected 6", got); end
        checks++;
        if (idx != 6) begin errors++; $display("FAIL bp_accepted got %0d expected 6", idx); end
    endtask

    // Alternating valid/bubble input keeps the bubbles in the output stream.
    task automatic test_bubbles();
        logic [7:0] sv [4];
        logic [1:0] so [4];
        logic       se [4];
        logic       exp_v;
        sv = '{8'hAA, 8'hAB, 8'h7F, 8'hFF};
        so = '{2'b10, 2'b10, 2'b00, 2'b11};
        se = '{1'b0, 1'b1, 1'b0, 1'b1};
        oready8 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            if (c < 8 && (c % 2) == 0) begin
                vec8 = sv[c/2]; op8 = so[c/2]; valid8 = 1'b1;
            end else begin
                vec8 = 8'h55; op8 = 2'b00; valid8 = 1'b0;
            end
            @(negedge clk);
            exp_v = (c >= 3 && c <= 9 && (c % 2) == 1);
            checks++;
            if (ovalid8 !== exp_v) begin
                errors++; $display("FAIL bubble_valid c=%0d got %b expected %b", c, ovalid8, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (obit8 !== se[(c-3)/2]) begin
                    errors++; $display("FAIL bubble_bit beat=%0d got %b expected %b", (c - 3) / 2, obit8, se[(c-3)/2]);
                end
            end
            next_cycle();
        end
    endtask

    // Short reset pulse with beats in flight discards them at once.
    task automatic test_reset_mid();
        logic exp_v;
        oready8 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vec8 = 8'hFF; op8 = 2'b00; valid8 = 1'b1;
            next_cycle();
        end
        valid8 = 1'b0;
        checks++;
        if (ovalid8 !== 1'b1) begin errors++; $display("FAIL mid_inflight_valid got %b expected 1", ovalid8); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ovalid8 !== 1'b0) begin errors++; $display("FAIL mid_async_clear got %b expected 0", ovalid8); end
        #1;
        rst_n = 1'b1;
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin
                vec8 = 8'h00; op8 = 2'b11; valid8 = 1'b1;
            end else begin
                valid8 = 1'b0;
            end
            @(negedge clk);
            exp_v = (c == 3);
            checks++;
            if (ovalid8 !== exp_v) begin
                errors++; $display("FAIL mid_after_valid c=%0d got %b expected %b", c, ovalid8, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (obit8 !== 1'b1) begin errors++; $display("FAIL mid_after_bit got %b expected 1", obit8); end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        idle(4);
        test_op_sweep();
        idle(4);
        test_non_pow2();
        idle(4);
        test_backpressure();
        idle(4);
        test_bubbles();
        idle(4);
        test_reset_mid();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
